// File: rtl/capture_pkg.sv
// Shared types and sizing helpers for the index capture FIFO.
package capture_pkg;

  localparam int N_DEF     = 64;
  localparam int DEPTH_DEF = 4;
  localparam int K_DEF     = $clog2(N_DEF);

  typedef struct packed {
    logic             valid;
    logic [K_DEF-1:0] idx;
  } sample_t;

  // Pointer width carries one extra wrap bit so full and empty are distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, occupancy count and sticky drop flag.
module sync_fifo
  import capture_pkg::*;
#(
  parameter int W     = 6,
  parameter int DEPTH = 4,
  parameter int PW    = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          empty,
  output logic          full,
  output logic [PW-1:0] count,
  output logic          overflow
);

  localparam int AW = PW - 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          ovf;
  logic          do_pop;
  logic          do_push;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[PW-1] != rptr[PW-1]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count    = wptr - rptr;
  assign rdata    = mem[rptr[AW-1:0]];
  assign overflow = ovf;

  // A pop frees the head slot in the same cycle, so a full FIFO still accepts a push.
  always_comb begin
    do_pop  = 1'b0;
    do_push = 1'b0;
    if (pop && !empty) begin
      do_pop = 1'b1;
    end else begin
      do_pop = 1'b0;
    end
    if (push && (!full || do_pop)) begin
      do_push = 1'b1;
    end else begin
      do_push = 1'b0;
    end
  end

  // Pointer and overflow state; clear discards any push or pop of its cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      ovf  <= 1'b0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
      ovf  <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + {{(PW-1){1'b0}}, 1'b1};
      if (do_pop)  rptr <= rptr + {{(PW-1){1'b0}}, 1'b1};
      if (push && !do_push) ovf <= 1'b1;
    end
  end

  // Storage array, reset so the head reads zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !clear) begin
      mem[wptr[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/index_capture_fifo.sv
// Samples an asynchronous one-hot encoder index, filters unstable samples,
// and queues each newly settled index into a small FIFO.
module index_capture_fifo
  import capture_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int K     = $clog2(N),
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [K-1:0]            in_idx,
  input  logic                    in_valid,
  input  logic                    clear,
  output logic [K-1:0]            out_idx,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ptr_w(DEPTH)-1:0] count,
  output logic                    overflow
);

  typedef struct packed {
    logic         valid;
    logic [K-1:0] idx;
  } stage_t;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || (2 ** K) < N) begin : g_bad_params
    $error("index_capture_fifo: illegal N/K/DEPTH combination");
  end

  stage_t       s1;
  stage_t       s2;
  logic         lv;
  logic [K-1:0] lidx;
  logic         stable;
  logic         fire;
  logic         empty;
  logic         full;

  // An event is a settled, valid index that differs from the last one captured.
  always_comb begin
    stable = (s1 == s2);
    fire   = 1'b0;
    if (stable && s2.valid && (!lv || (lidx != s2.idx))) begin
      fire = 1'b1;
    end else begin
      fire = 1'b0;
    end
  end

  // Two-stage sampler plus last-accepted record; unstable samples leave the record alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      lv   <= 1'b0;
      lidx <= '0;
    end else begin
      s1 <= '{valid: in_valid, idx: in_idx};
      s2 <= s1;
      if (clear) begin
        lv <= 1'b0;
      end else if (stable) begin
        if (!s2.valid) begin
          lv <= 1'b0;
        end else if (fire) begin
          lv   <= 1'b1;
          lidx <= s2.idx;
        end
      end
    end
  end

  sync_fifo #(
    .W     (K),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .push     (fire),
    .wdata    (s2.idx),
    .pop      (out_ready),
    .rdata    (out_idx),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );

  assign out_valid = !empty;

endmodule

// File: tb/tb_index_capture_fifo.sv
// Self-checking bench for index_capture_fifo: table vectors plus corner sequences
// with a scoreboard queue of expected FIFO contents.
module tb_index_capture_fifo;
  import capture_pkg::*;

  localparam int N     = 64;
  localparam int K     = 6;
  localparam int DEPTH = 4;
  localparam int CW    = ptr_w(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [K-1:0]  in_idx;
  logic          in_valid;
  logic          clear;
  logic [K-1:0]  out_idx;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          overflow;

  int n_cmp = 0;
  int n_bad = 0;
  logic [K-1:0] sb[$];

  typedef struct {
    logic         valid;
    logic [K-1:0] idx;
    int           hold;
    bit           push;
    int           exp_count;
  } vec_t;

  vec_t tbl[4];

  index_capture_fifo #(.N(N), .K(K), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_idx    (in_idx),
    .in_valid  (in_valid),
    .clear     (clear),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic apply(input logic v, input logic [K-1:0] idx, input int n);
    in_valid = v;
    in_idx   = idx;
    repeat (n) step();
  endtask

  task automatic drain(input string tag);
    logic [K-1:0] exp_idx;
    out_ready = 1'b1;
    while (sb.size() > 0) begin
      exp_idx = sb.pop_front();
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_idx"}, 32'(out_idx), 32'(exp_idx));
      step();
    end
    out_ready = 1'b0;
    check({tag, "_empty"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int seen;
    logic [K-1:0] head;

    tbl[0] = '{valid: 1'b1, idx: 6'd3, hold: 4, push: 1'b1, exp_count: 1};
    tbl[1] = '{valid: 1'b0, idx: 6'd0, hold: 4, push: 1'b0, exp_count: 1};
    tbl[2] = '{valid: 1'b1, idx: 6'd3, hold: 4, push: 1'b1, exp_count: 2};
    tbl[3] = '{valid: 1'b1, idx: 6'd7, hold: 4, push: 1'b1, exp_count: 3};

    rst_n = 1'b0; in_valid = 1'b0; in_idx = '0; clear = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_idx", 32'(out_idx), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Held index: single entry, three-edge latency.
    in_valid = 1'b1; in_idx = 6'd5;
    seen = 0;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (out_valid) begin
        seen = e;
        break;
      end
    end
    check("latency_edges", 32'(seen), 32'd3);
    repeat (7) step();
    check("hold_count", 32'(count), 32'd1);
    sb.push_back(6'd5);
    drain("hold");
    apply(1'b0, 6'd0, 4);

    // Toggling index never settles, then settles on 9.
    for (int i = 0; i < 6; i++) apply(1'b1, (i % 2 == 0) ? 6'd5 : 6'd9, 1);
    check("toggle_none", 32'(count), 32'd0);
    apply(1'b1, 6'd9, 6);
    check("toggle_count", 32'(count), 32'd1);
    sb.push_back(6'd9);
    drain("toggle");
    apply(1'b0, 6'd0, 4);

    // Table: repeat after release is captured again.
    for (int t = 0; t < 4; t++) begin
      apply(tbl[t].valid, tbl[t].idx, tbl[t].hold);
      if (tbl[t].push) sb.push_back(tbl[t].idx);
      check($sformatf("tbl%0d_count", t), 32'(count), 32'(tbl[t].exp_count));
    end
    check("tbl_ovf", 32'(overflow), 32'd0);
    drain("tbl");
    apply(1'b0, 6'd0, 4);

    // Overflow with five distinct indices, then clear.
    for (int i = 0; i < 5; i++) apply(1'b1, 6'(1 << i), 4);
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_head", 32'(out_idx), 32'd1);
    apply(1'b0, 6'd0, 4);
    check("ovf_sticky", 32'(overflow), 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_count", 32'(count), 32'd0);
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_valid", 32'(out_valid), 32'd0);
    step();

    // Full FIFO with push and pop on the same edge.
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 6'(10 + i), 4);
      sb.push_back(6'(10 + i));
    end
    check("full_count", 32'(count), 32'd4);
    in_valid = 1'b1; in_idx = 6'd14;
    step();
    step();
    head = sb.pop_front();
    check("pp_head", 32'(out_idx), 32'(head));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    sb.push_back(6'd14);
    check("pp_count", 32'(count), 32'd4);
    check("pp_ovf", 32'(overflow), 32'd0);
    drain("pp");
    apply(1'b0, 6'd0, 4);

    // Reset mid-stream with two entries queued.
    apply(1'b1, 6'd20, 4);
    apply(1'b1, 6'd21, 4);
    check("mid_count", 32'(count), 32'd2);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_count", 32'(count), 32'd0);
    check("mrst_ovf", 32'(overflow), 32'd0);
    check("mrst_idx", 32'(out_idx), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) step();
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_count", 32'(count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
